// File: rtl/rtc_bus_scheduler_if.sv
// Requester handshake plus RTC pad signals shared between the scheduler
// and its environment. The scheduler itself uses the master view.
`timescale 1ns/1ps
interface rtc_bus_scheduler_if;
  logic       req_clr;
  logic       req_wr;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       CSO;
  logic       ADO;
  logic       WRO;
  logic       RDO;
  logic       clr_ack;
  logic       wr_ack;
  logic       rd_valid;
  logic [2:0] rd_idx;
  logic [7:0] rd_data;
  logic       busy;

  modport master (
    input  req_clr, req_wr, wr_addr, wr_data, bus_in,
    output bus_out, bus_oe, CSO, ADO, WRO, RDO,
    output clr_ack, wr_ack, rd_valid, rd_idx, rd_data, busy
  );

  modport slave (
    output req_clr, req_wr, wr_addr, wr_data, bus_in,
    input  bus_out, bus_oe, CSO, ADO, WRO, RDO,
    input  clr_ack, wr_ack, rd_valid, rd_idx, rd_data, busy
  );
endinterface

// File: rtl/rtc_bus_scheduler.sv
// Arbitrates clear / user-write / periodic refresh-read onto the multiplexed
// RTC bus and sequences one address+data transaction per grant.
`timescale 1ns/1ps
module rtc_bus_scheduler #(
  parameter int unsigned T_PULSE     = 4,
  parameter int unsigned T_GAP       = 2,
  parameter int unsigned REFRESH_CYC = 1000,
  parameter int unsigned N_READ      = 6,
  parameter logic [7:0]  READ_BASE   = 8'h21,
  parameter logic [7:0]  CLR_ADDR    = 8'h02,
  parameter logic [7:0]  CLR_DATA    = 8'h10
) (
  input logic                 CLK,
  input logic                 Reset,
  rtc_bus_scheduler_if.master bus
);

  localparam int unsigned PH_MAX = (T_PULSE > T_GAP) ? T_PULSE : T_GAP;
  localparam int unsigned CW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int unsigned RW     = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
  localparam logic [CW-1:0] PULSE_LAST = CW'(T_PULSE - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(T_GAP - 1);
  localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_CYC - 1);
  localparam logic [2:0]    IDX_LAST   = 3'(N_READ - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_AGAP, S_DATA, S_DGAP, S_DONE} state_t;
  typedef enum logic [1:0] {K_CLR, K_WR, K_RD} kind_t;

  state_t        state_reg, state_next;
  kind_t         kind_reg, kind_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [7:0]    addr_reg, addr_next;
  logic [7:0]    data_reg, data_next;
  logic [RW-1:0] ref_cnt_reg, ref_cnt_next;
  logic          pend_reg, pend_next;
  logic [2:0]    idx_reg, idx_next;
  logic [7:0]    cap_reg;

  logic       cso_reg, ado_reg, wro_reg, rdo_reg, oe_reg;
  logic       cso_next, ado_next, wro_next, rdo_next, oe_next;
  logic [7:0] out_reg, out_next;
  logic       clr_ack_reg, wr_ack_reg, rd_valid_reg, busy_reg;
  logic       clr_ack_next, wr_ack_next, rd_valid_next, busy_next;
  logic [2:0] rd_idx_reg;
  logic [7:0] rd_data_reg;

  logic done_rd, last_rd, wrap, cap_en;

  always_comb begin
    state_next = state_reg;
    kind_next  = kind_reg;
    cnt_next   = cnt_reg + 1'b1;
    addr_next  = addr_reg;
    data_next  = data_reg;
    case (state_reg)
      S_IDLE: begin
        cnt_next = '0;
        if (bus.req_clr) begin
          state_next = S_ADDR;
          kind_next  = K_CLR;
          addr_next  = CLR_ADDR;
          data_next  = CLR_DATA;
        end else if (bus.req_wr) begin
          state_next = S_ADDR;
          kind_next  = K_WR;
          addr_next  = bus.wr_addr;
          data_next  = bus.wr_data;
        end else if (pend_reg) begin
          state_next = S_ADDR;
          kind_next  = K_RD;
          addr_next  = READ_BASE + {5'd0, idx_reg};
          data_next  = '0;
        end
      end
      S_ADDR: if (cnt_reg == PULSE_LAST) begin state_next = S_AGAP; cnt_next = '0; end
      S_AGAP: if (cnt_reg == GAP_LAST)   begin state_next = S_DATA; cnt_next = '0; end
      S_DATA: if (cnt_reg == PULSE_LAST) begin state_next = S_DGAP; cnt_next = '0; end
      S_DGAP: if (cnt_reg == GAP_LAST)   begin state_next = S_DONE; cnt_next = '0; end
      S_DONE: begin state_next = S_IDLE; cnt_next = '0; end
      default: begin state_next = S_IDLE; cnt_next = '0; end
    endcase
  end

  // A refresh wrap that lands while a burst is still pending is dropped.
  always_comb begin
    done_rd      = (state_next == S_DONE) && (kind_reg == K_RD);
    last_rd      = done_rd && (idx_reg == IDX_LAST);
    wrap         = (ref_cnt_reg == REF_LAST);
    ref_cnt_next = wrap ? '0 : ref_cnt_reg + 1'b1;
    pend_next    = pend_reg ? !last_rd : wrap;
    idx_next     = idx_reg;
    if (done_rd) idx_next = last_rd ? 3'd0 : idx_reg + 3'd1;
    cap_en = (state_reg == S_DATA) && (cnt_reg == PULSE_LAST) && (kind_reg == K_RD);
  end

  // Outputs are decoded from the next state so every pin is a flop output.
  always_comb begin
    cso_next = 1'b1;
    ado_next = 1'b1;
    wro_next = 1'b1;
    rdo_next = 1'b1;
    oe_next  = 1'b0;
    out_next = '0;
    case (state_next)
      S_ADDR: begin
        cso_next = 1'b0; ado_next = 1'b0; wro_next = 1'b0;
        oe_next  = 1'b1; out_next = addr_next;
      end
      S_AGAP: begin
        ado_next = 1'b0; oe_next = 1'b1; out_next = addr_next;
      end
      S_DATA: begin
        cso_next = 1'b0;
        if (kind_next == K_RD) begin
          rdo_next = 1'b0;
        end else begin
          wro_next = 1'b0; oe_next = 1'b1; out_next = data_next;
        end
      end
      default: ;
    endcase
    clr_ack_next  = (state_next == S_DONE) && (kind_next == K_CLR);
    wr_ack_next   = (state_next == S_DONE) && (kind_next == K_WR);
    rd_valid_next = (state_next == S_DONE) && (kind_next == K_RD);
    busy_next     = (state_next != S_IDLE);
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_reg    <= S_IDLE;
      kind_reg     <= K_CLR;
      cnt_reg      <= '0;
      addr_reg     <= '0;
      data_reg     <= '0;
      ref_cnt_reg  <= '0;
      pend_reg     <= 1'b0;
      idx_reg      <= '0;
      cap_reg      <= '0;
      cso_reg      <= 1'b1;
      ado_reg      <= 1'b1;
      wro_reg      <= 1'b1;
      rdo_reg      <= 1'b1;
      oe_reg       <= 1'b0;
      out_reg      <= '0;
      clr_ack_reg  <= 1'b0;
      wr_ack_reg   <= 1'b0;
      rd_valid_reg <= 1'b0;
      busy_reg     <= 1'b0;
      rd_idx_reg   <= '0;
      rd_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      kind_reg     <= kind_next;
      cnt_reg      <= cnt_next;
      addr_reg     <= addr_next;
      data_reg     <= data_next;
      ref_cnt_reg  <= ref_cnt_next;
      pend_reg     <= pend_next;
      idx_reg      <= idx_next;
      if (cap_en) cap_reg <= bus.bus_in;
      cso_reg      <= cso_next;
      ado_reg      <= ado_next;
      wro_reg      <= wro_next;
      rdo_reg      <= rdo_next;
      oe_reg       <= oe_next;
      out_reg      <= out_next;
      clr_ack_reg  <= clr_ack_next;
      wr_ack_reg   <= wr_ack_next;
      rd_valid_reg <= rd_valid_next;
      busy_reg     <= busy_next;
      if (rd_valid_next) begin
        rd_idx_reg  <= idx_reg;
        rd_data_reg <= cap_reg;
      end
    end
  end

  assign bus.CSO      = cso_reg;
  assign bus.ADO      = ado_reg;
  assign bus.WRO      = wro_reg;
  assign bus.RDO      = rdo_reg;
  assign bus.bus_oe   = oe_reg;
  assign bus.bus_out  = out_reg;
  assign bus.clr_ack  = clr_ack_reg;
  assign bus.wr_ack   = wr_ack_reg;
  assign bus.rd_valid = rd_valid_reg;
  assign bus.rd_idx   = rd_idx_reg;
  assign bus.rd_data  = rd_data_reg;
  assign bus.busy     = busy_reg;

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Directed bench for rtc_bus_scheduler: a table-driven write trace plus
// hand-timed sequences for refresh, arbitration, reset abort and lost wraps.
`timescale 1ns/1ps
module tb_rtc_bus_scheduler;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  rtc_bus_scheduler_if bif();

  rtc_bus_scheduler #(
    .T_PULSE(4), .T_GAP(2), .REFRESH_CYC(50), .N_READ(3),
    .READ_BASE(8'h21), .CLR_ADDR(8'h02), .CLR_DATA(8'h10)
  ) dut (
    .CLK(clk),
    .Reset(rst_n),
    .bus(bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge count since reset release: at the negedge after edge n, cyc == n.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (bif.clr_ack)  $display("txn clear done  t=%0t", $time);
    if (bif.wr_ack)   $display("txn write done  t=%0t", $time);
    if (bif.rd_valid) $display("txn read  done  t=%0t idx=%0d data=%02h", $time, bif.rd_idx, bif.rd_data);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    string      name;
    int         reps;
    logic       req_after;
    logic [4:0] strb;      // {CSO, ADO, WRO, RDO, bus_oe}
    logic [7:0] out;
    logic       ack;
    logic       busy;
  } vec_t;

  vec_t tbl [6];

  function automatic vec_t mk(input string nm, input int r, input logic rq,
                              input logic [4:0] s, input logic [7:0] o,
                              input logic a, input logic b);
    vec_t v;
    v.name = nm; v.reps = r; v.req_after = rq; v.strb = s;
    v.out = o; v.ack = a; v.busy = b;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bif.req_clr = 1'b0;
    bif.req_wr  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int nrv;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bif.req_clr = 1'b0;
    bif.req_wr  = 1'b0;
    bif.wr_addr = 8'h00;
    bif.wr_data = 8'h00;
    bif.bus_in  = 8'hAA;

    tbl[0] = mk("addr", 4, 1'b1, 5'b00011, 8'h23, 1'b0, 1'b1);
    tbl[1] = mk("agap", 2, 1'b1, 5'b10111, 8'h23, 1'b0, 1'b1);
    tbl[2] = mk("data", 4, 1'b1, 5'b01011, 8'h08, 1'b0, 1'b1);
    tbl[3] = mk("dgap", 2, 1'b1, 5'b11110, 8'h00, 1'b0, 1'b1);
    tbl[4] = mk("done", 1, 1'b0, 5'b11110, 8'h00, 1'b1, 1'b1);
    tbl[5] = mk("idle", 2, 1'b0, 5'b11110, 8'h00, 1'b0, 1'b0);

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_state",
          {bif.CSO, bif.ADO, bif.WRO, bif.RDO, bif.bus_oe, bif.bus_out, bif.clr_ack,
           bif.wr_ack, bif.rd_valid, bif.rd_idx, bif.rd_data, bif.busy},
          {5'b11110, 8'h00, 3'b000, 3'd0, 8'h00, 1'b0});

    // Write trace, table driven; address/data changed after grant must be ignored
    do_reset();
    bif.req_wr = 1'b1; bif.wr_addr = 8'h23; bif.wr_data = 8'h08;
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < tbl[i].reps; j++) begin
        @(negedge clk);
        check(tbl[i].name,
              {bif.CSO, bif.ADO, bif.WRO, bif.RDO, bif.bus_oe, bif.bus_out, bif.wr_ack, bif.busy},
              {tbl[i].strb, tbl[i].out, tbl[i].ack, tbl[i].busy});
        bif.req_wr = tbl[i].req_after;
        if (i == 0 && j == 0) begin
          bif.wr_addr = 8'hFF; bif.wr_data = 8'hFF;
        end
      end
    end

    // Refresh burst: grants at 51, 65, 79; data sampled at end of DATA only
    do_reset();
    bif.bus_in = 8'hAA;
    for (int r = 0; r < 3; r++) begin
      int g;
      logic [7:0] ea;
      logic [7:0] ed;
      g  = 51 + 14 * r;
      ea = 8'h21 + 8'(r);
      ed = 8'h35 + 8'(r);
      wait_cyc(g);
      check("rd_addr", {bif.CSO, bif.ADO, bif.bus_oe, bif.bus_out}, {3'b001, ea});
      wait_cyc(g + 6);
      check("rd_data_phase", {bif.CSO, bif.ADO, bif.WRO, bif.RDO, bif.bus_oe}, {5'b01100});
      wait_cyc(g + 9);
      bif.bus_in = ed;
      wait_cyc(g + 10);
      bif.bus_in = 8'hAA;
      wait_cyc(g + 12);
      check("rd_valid", {bif.rd_valid, bif.rd_idx, bif.rd_data}, {1'b1, 3'(r), ed});
    end
    wait_cyc(100);
    check("burst_gap_idle", {31'd0, bif.busy}, 32'd0);
    wait_cyc(101);
    check("burst2_start", {bif.busy, bif.ADO, bif.bus_out}, {2'b10, 8'h21});

    // Clear and write together: clear first, write on the IDLE cycle after clr_ack
    do_reset();
    bif.req_clr = 1'b1; bif.req_wr = 1'b1; bif.wr_addr = 8'h45; bif.wr_data = 8'h67;
    wait_cyc(1);
    check("clr_addr", {bif.ADO, bif.bus_out}, {1'b0, 8'h02});
    wait_cyc(7);
    check("clr_data", {bif.ADO, bif.WRO, bif.bus_out}, {2'b10, 8'h10});
    wait_cyc(13);
    check("clr_ack", {bif.clr_ack, bif.wr_ack}, {2'b10});
    bif.req_clr = 1'b0;
    wait_cyc(14);
    check("clr_idle", {31'd0, bif.busy}, 32'd0);
    wait_cyc(15);
    check("wr_after_clr", {bif.busy, bif.ADO, bif.bus_out}, {2'b10, 8'h45});
    wait_cyc(21);
    check("wr_after_clr_data", {bif.ADO, bif.bus_out}, {1'b1, 8'h67});
    wait_cyc(27);
    check("wr_ack_after_clr", {bif.clr_ack, bif.wr_ack}, {2'b01});
    bif.req_wr = 1'b0;
    wait_cyc(29);
    check("no_reserve", {31'd0, bif.busy}, 32'd0);

    // Write interleaved into a refresh burst after idx 1
    do_reset();
    bif.bus_in = 8'h5A;
    wait_cyc(66);
    bif.req_wr = 1'b1; bif.wr_addr = 8'h30; bif.wr_data = 8'h31;
    wait_cyc(77);
    check("ilv_rd1", {bif.rd_valid, bif.rd_idx, bif.rd_data}, {1'b1, 3'd1, 8'h5A});
    wait_cyc(79);
    check("ilv_wr_addr", {bif.CSO, bif.ADO, bif.bus_out}, {2'b00, 8'h30});
    wait_cyc(91);
    check("ilv_wr_ack", {31'd0, bif.wr_ack}, 32'd1);
    bif.req_wr = 1'b0;
    wait_cyc(93);
    check("ilv_rd2_addr", {bif.ADO, bif.bus_out}, {1'b0, 8'h23});
    wait_cyc(105);
    check("ilv_rd2_valid", {bif.rd_valid, bif.rd_idx}, {1'b1, 3'd2});
    wait_cyc(107);
    check("ilv_pend_clear", {31'd0, bif.busy}, 32'd0);

    // Asynchronous reset during DATA of a write aborts it; request re-served
    do_reset();
    bif.req_wr = 1'b1; bif.wr_addr = 8'h44; bif.wr_data = 8'h55;
    wait_cyc(8);
    check("abort_in_data", {bif.WRO, bif.bus_out}, {1'b0, 8'h55});
    rst_n = 1'b0;
    #1;
    check("abort_async",
          {bif.CSO, bif.WRO, bif.RDO, bif.ADO, bif.bus_oe, bif.busy, bif.wr_ack, bif.bus_out},
          {7'b1111000, 8'h00});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(1);
    check("retry_addr", {bif.ADO, bif.bus_out}, {1'b0, 8'h44});
    wait_cyc(12);
    check("retry_no_early_ack", {31'd0, bif.wr_ack}, 32'd0);
    wait_cyc(13);
    check("retry_ack", {31'd0, bif.wr_ack}, 32'd1);
    bif.req_wr = 1'b0;

    // Continuous writes starve refresh; lost wraps must not queue extra bursts
    do_reset();
    bif.req_wr = 1'b1; bif.wr_addr = 8'h11; bif.wr_data = 8'h22;
    for (int n = 0; n < 12; n++) begin
      wait_cyc(13 + 14 * n);
      check("stream_ack", {31'd0, bif.wr_ack}, 32'd1);
      bif.req_wr = 1'b0;
      wait_cyc(14 + 14 * n);
      if (n < 11) bif.req_wr = 1'b1;
    end
    wait_cyc(169);
    check("stream_burst_start", {bif.ADO, bif.bus_out}, {1'b0, 8'h21});
    nrv = 0;
    for (int c = 170; c <= 250; c++) begin
      wait_cyc(c);
      if (bif.rd_valid) nrv++;
    end
    check("stream_one_burst", 32'(nrv), 32'd3);
    wait_cyc(251);
    check("stream_next_burst", {bif.busy, bif.bus_out}, {1'b1, 8'h21});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
